// File: rtl/fifo_asym_pkg.sv
// rtl/fifo_asym_pkg.sv - shared types and helpers for the asymmetric FIFO write arbiter
package fifo_asym_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits, even for a count of one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_asym_wr_arb_rr_pick.sv
// rtl/fifo_asym_wr_arb_rr_pick.sv - combinational rotating-priority encoder
module rr_pick
  import fifo_asym_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  int w_best;
  int w_dist;

  // Winner is the set bit with the smallest forward distance from the pointer.
  always_comb begin
    o_idx  = '0;
    w_best = NREQ;
    w_dist = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (i_req[j]) begin
        w_dist = (j + NREQ - int'(i_ptr)) % NREQ;
        if (w_dist < w_best) begin
          w_best = w_dist;
          o_idx  = IW'(j);
        end
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/fifo_asym_wr_arb.sv
// rtl/fifo_asym_wr_arb.sv - round-robin burst arbiter for the double-width FIFO write port
module fifo_asym_wr_arb
  import fifo_asym_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  parameter int CWIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*2*DWIDTH-1:0]     req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [2*DWIDTH-1:0]          fifo_din,
  output logic                         fifo_w_en,
  input  logic                         fifo_full,
  output logic [clog2_min1(NREQ)-1:0]  grant_id,
  output logic                         busy,
  output logic [CWIDTH-1:0]            wr_count
);

  localparam int IW = clog2_min1(NREQ);
  localparam int BW = clog2_min1(BURST);
  localparam int WW = 2 * DWIDTH;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NREQ - 1);

  arb_state_t        r_state;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_grant_id;
  logic [BW-1:0]     r_beat_cnt;
  logic [CWIDTH-1:0] r_wr_count;

  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_any;
  logic              w_sel_valid;
  logic [WW-1:0]     w_sel_data;
  logic              w_grant;
  logic              w_xfer;
  logic              w_release;
  logic [IW-1:0]     w_next_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant_id == IW'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_data  = req_data[i*WW +: WW];
      end
    end
  end

  assign w_grant    = (r_state == ARB_GRANT);
  // Full gates the write combinationally so nothing is ever issued into a full FIFO.
  assign w_xfer     = w_grant & w_sel_valid & ~fifo_full;
  assign w_release  = w_grant & ((w_xfer & (r_beat_cnt == LAST_BEAT)) | ~w_sel_valid);
  assign w_next_ptr = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant & (r_grant_id == IW'(i)) & ~fifo_full;
    end
  end

  assign fifo_w_en = w_xfer;
  assign fifo_din  = w_grant ? w_sel_data : '0;
  assign busy      = w_grant;
  assign grant_id  = r_grant_id;
  assign wr_count  = r_wr_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            r_wr_count <= r_wr_count + 1'b1;
          end
          // A full stall is not a release; the grant is held until data moves or valid drops.
          if (w_release) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_asym_wr_arb.sv
// tb/tb_fifo_asym_wr_arb.sv - self-checking bench for the FIFO write arbiter
module tb_fifo_asym_wr_arb;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic [15:0] fifo_din;
  logic        fifo_w_en;
  logic        fifo_full;
  logic [0:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  logic [2:0]  req_valid2;
  logic [47:0] req_data2;
  logic [2:0]  req_ready2;
  logic [15:0] fifo_din2;
  logic        fifo_w_en2;
  logic        fifo_full2;
  logic [1:0]  grant_id2;
  logic        busy2;
  logic [3:0]  wr_count2;

  always #5 clk = ~clk;

  fifo_asym_wr_arb #(.NREQ(2), .DWIDTH(8), .BURST(4), .CWIDTH(16)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_din(fifo_din), .fifo_w_en(fifo_w_en),
    .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );

  fifo_asym_wr_arb #(.NREQ(3), .DWIDTH(8), .BURST(1), .CWIDTH(4)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .fifo_din(fifo_din2), .fifo_w_en(fifo_w_en2),
    .fifo_full(fifo_full2), .grant_id(grant_id2), .busy(busy2), .wr_count(wr_count2)
  );

  typedef struct {
    logic        busy;
    logic        w_en;
    logic        ready0;
    logic [15:0] din;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] src0[$];
  logic [15:0] src1[$];
  logic [16:0] sb[$];
  int          fifo_cnt = 0;
  int          fifo_depth = 16;
  bit          drain = 1'b1;
  bit          acc0, acc1, wrote;
  int          n_wr = 0;
  int          n2 = 0;
  int          n2_limit = 0;
  bit          prev_w2 = 1'b0;
  vec_t        tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    req_valid[0]     = (src0.size() > 0);
    req_valid[1]     = (src1.size() > 0);
    req_data[15:0]   = (src0.size() > 0) ? src0[0] : 16'h0;
    req_data[31:16]  = (src1.size() > 0) ? src1[0] : 16'h0;
    fifo_full        = (fifo_cnt >= fifo_depth);
  endtask

  task automatic sample();
    logic [16:0] e;
    @(negedge clk);
    acc0  = req_valid[0] & req_ready[0];
    acc1  = req_valid[1] & req_ready[1];
    wrote = fifo_w_en;
    if (fifo_full) begin
      chk("full_ready", 32'(req_ready), 32'h0);
      chk("full_w_en", 32'(fifo_w_en), 32'h0);
    end
    if (fifo_w_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_write: got din 0x%0h, expected no write", fifo_din);
      end else begin
        e = sb.pop_front();
        chk("wr_data", 32'(fifo_din), 32'(e[15:0]));
        chk("wr_grant", 32'(grant_id), 32'(e[16]));
      end
    end
    if (fifo_w_en2) begin
      chk("rr3_grant", 32'(grant_id2), 32'(n2 % 3));
      chk("rr3_din", 32'(fifo_din2), 32'h00C0 + 32'(n2 % 3));
      chk("b1_gap", 32'(prev_w2), 32'h0);
      n2++;
    end
    prev_w2 = fifo_w_en2;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    if (acc0) void'(src0.pop_front());
    if (acc1) void'(src1.pop_front());
    if (drain && fifo_cnt > 0) fifo_cnt--;
    if (wrote) fifo_cnt++;
    if (n2 >= n2_limit) req_valid2 = 3'b000;
    acc0  = 1'b0;
    acc1  = 1'b0;
    wrote = 1'b0;
    refresh();
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic run_until_empty(input int bound);
    for (int i = 0; i < bound && sb.size() > 0; i++) step();
    chk("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    src0.delete();
    src1.delete();
    sb.delete();
    fifo_cnt   = 0;
    fifo_depth = 16;
    drain      = 1'b1;
    refresh();
    sample();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_w_en", 32'(fifo_w_en), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_din", 32'(fifo_din), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_wr_count", 32'(wr_count), 32'h0);
    chk("rst_wr_count2", 32'(wr_count2), 32'h0);
    advance();
    rstn = 1'b1;
    n_wr = 0;
  endtask

  initial begin
    // busy, w_en, ready0, din for a single requester sending 6 words
    tv[0] = '{1'b0, 1'b0, 1'b0, 16'h0000};
    tv[1] = '{1'b1, 1'b1, 1'b1, 16'h0100};
    tv[2] = '{1'b1, 1'b1, 1'b1, 16'h0101};
    tv[3] = '{1'b1, 1'b1, 1'b1, 16'h0102};
    tv[4] = '{1'b1, 1'b1, 1'b1, 16'h0103};
    tv[5] = '{1'b0, 1'b0, 1'b0, 16'h0000};
    tv[6] = '{1'b1, 1'b1, 1'b1, 16'h0104};
    tv[7] = '{1'b1, 1'b1, 1'b1, 16'h0105};
    tv[8] = '{1'b1, 1'b0, 1'b1, 16'h0000};
    tv[9] = '{1'b0, 1'b0, 1'b0, 16'h0000};

    rstn       = 1'b0;
    req_valid  = 2'b00;
    req_data   = 32'h0;
    fifo_full  = 1'b0;
    fifo_full2 = 1'b0;
    req_valid2 = 3'b000;
    req_data2  = {16'h00C2, 16'h00C1, 16'h00C0};
    acc0 = 1'b0; acc1 = 1'b0; wrote = 1'b0;

    // single requester, table-driven cycle pattern
    do_reset();
    for (int i = 0; i < 6; i++) begin
      src0.push_back(16'(16'h0100 + i));
      sb.push_back({1'b0, 16'(16'h0100 + i)});
    end
    refresh();
    for (int r = 0; r < 10; r++) begin
      sample();
      chk($sformatf("t1_busy[%0d]", r), 32'(busy), 32'(tv[r].busy));
      chk($sformatf("t1_w_en[%0d]", r), 32'(fifo_w_en), 32'(tv[r].w_en));
      chk($sformatf("t1_ready0[%0d]", r), 32'(req_ready[0]), 32'(tv[r].ready0));
      chk($sformatf("t1_din[%0d]", r), 32'(fifo_din), 32'(tv[r].din));
      chk($sformatf("t1_grant[%0d]", r), 32'(grant_id), 32'h0);
      advance();
    end
    chk("t1_wr_count", 32'(wr_count), 32'd6);

    // both requesters streaming: alternating bursts of 4
    do_reset();
    for (int i = 0; i < 32; i++) begin
      src0.push_back(16'(16'hA000 + i));
      src1.push_back(16'(16'hB000 + i));
    end
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 4; k++)
        sb.push_back((b % 2 == 0) ? {1'b0, 16'(16'hA000 + (b / 2) * 4 + k)}
                                  : {1'b1, 16'(16'hB000 + (b / 2) * 4 + k)});
    refresh();
    run_until_empty(200);
    chk("t2_wr_count", 32'(wr_count), 32'd64);

    // backpressure: depth-6 FIFO fills mid-burst, then single reads
    do_reset();
    fifo_depth = 6;
    drain      = 1'b0;
    for (int i = 0; i < 20; i++) src0.push_back(16'(16'hA100 + i));
    for (int i = 0; i < 8; i++) sb.push_back({1'b0, 16'(16'hA100 + i)});
    refresh();
    for (int i = 0; i < 25; i++) step();
    chk("t3_fill_writes", 32'(n_wr), 32'd6);
    chk("t3_full", 32'(fifo_full), 32'h1);
    fifo_cnt--;
    refresh();
    for (int i = 0; i < 4; i++) step();
    chk("t3_one_after_read", 32'(n_wr), 32'd7);
    fifo_cnt--;
    refresh();
    step();
    chk("t3_two_after_reads", 32'(n_wr), 32'd8);
    sample();
    chk("t3_release_after_stall", 32'(busy), 32'h0);
    advance();
    chk("t3_wr_count", 32'(wr_count), 32'd8);
    chk("t3_sb_empty", 32'(sb.size()), 32'h0);

    // early drop by requester 1, requester 0 granted next
    do_reset();
    src1.push_back(16'hB100);
    src1.push_back(16'hB101);
    sb.push_back({1'b1, 16'hB100});
    sb.push_back({1'b1, 16'hB101});
    refresh();
    step();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(16'(16'hA200 + i));
      sb.push_back({1'b0, 16'(16'hA200 + i)});
    end
    refresh();
    run_until_empty(40);
    chk("t4_wr_count", 32'(wr_count), 32'd6);

    // asynchronous reset two words into requester 1's burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(16'(16'hA300 + i));
      sb.push_back({1'b0, 16'(16'hA300 + i)});
    end
    for (int i = 0; i < 8; i++) src1.push_back(16'(16'hB300 + i));
    sb.push_back({1'b1, 16'hB300});
    sb.push_back({1'b1, 16'hB301});
    refresh();
    run_until_empty(40);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'h0);
    chk("t5_rst_w_en", 32'(fifo_w_en), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_wr_count", 32'(wr_count), 32'h0);
    chk("t5_rst_din", 32'(fifo_din), 32'h0);
    src0.delete();
    for (int i = 0; i < 4; i++) begin
      src0.push_back(16'(16'hC300 + i));
      sb.push_back({1'b0, 16'(16'hC300 + i)});
    end
    for (int i = 2; i < 6; i++) sb.push_back({1'b1, 16'(16'hB300 + i)});
    refresh();
    rstn = 1'b1;
    run_until_empty(60);
    chk("t5_wr_count", 32'(wr_count), 32'd8);

    // three requesters, BURST=1, 4-bit counter wraps after 17 writes
    do_reset();
    n2       = 0;
    n2_limit = 17;
    prev_w2  = 1'b0;
    req_valid2 = 3'b111;
    for (int i = 0; i < 100 && n2 < 17; i++) step();
    for (int i = 0; i < 3; i++) step();
    chk("t6_writes", 32'(n2), 32'd17);
    chk("t6_wr_count_wrap", 32'(wr_count2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
